lcd_nibble_writer: RTL

- Downstream physical-interface stage for the time-of-day display path.
- The formatting logic upstream presents whole LCD bytes (command or character) through a valid/ready handshake. This block splits each byte into two HD44780 4-bit bus transfers and enforces setup, enable-pulse, hold and execution timing on rs/en/data[7:4].
- Runs the power-up 4-bit-mode entry sequence itself. Upstream therefore never drives raw nibbles or counts delays.

---
 rtl/lcd_nibble_writer_if.sv | 11 +
 rtl/lcd_nibble_writer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_writer_if.sv
// Byte handshake between the display formatter (master) and the LCD nibble writer (slave).
// The formatter presents a whole LCD byte and its register select; the writer answers with ready.
interface lcd_nibble_writer_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       in_rs;

   modport master (output in_valid, output in_byte, output in_rs, input in_ready);
   modport slave  (input in_valid, input in_byte, input in_rs, output in_ready);
endinterface

// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit bus driver: runs the power-up 4-bit entry sequence, then splits each accepted
// byte into two timed nibble transfers on rs/en/data and enforces the post-byte execution wait.
module lcd_nibble_writer #(
   parameter int unsigned POWERUP_CYCLES   = 60000,
   parameter int unsigned SETUP_CYCLES     = 4,
   parameter int unsigned EN_HIGH_CYCLES   = 800,
   parameter int unsigned HOLD_CYCLES      = 4,
   parameter int unsigned CMD_WAIT_CYCLES  = 2000,
   parameter int unsigned LONG_WAIT_CYCLES = 80000,
   parameter int unsigned CNT_W            = 17
) (
   input  logic                clk,
   input  logic                rst_n,
   lcd_nibble_writer_if.slave  up,
   output logic                init_done,
   output logic                busy,
   output logic                rs,
   output logic                en,
   output logic [3:0]          data
);

   typedef enum logic [2:0] {
      PWR_WAIT, INIT_NIB, INIT_GAP, IDLE, NIB_SETUP, NIB_EN, NIB_HOLD, GAP
   } state_t;

   state_t           r_state, w_stateNext;
   logic [CNT_W-1:0] r_cnt, w_cntNext;
   logic [1:0]       r_initIdx, w_initIdxNext;
   logic             r_lowNib, w_lowNibNext;
   logic [7:0]       r_byte, w_byteNext;
   logic             r_rsLat, w_rsLatNext;
   logic             r_rs, w_rsNext;
   logic [3:0]       r_data, w_dataNext;
   logic             r_initDone, w_initDoneNext;
   logic             r_en, r_ready, r_busy;
   logic             w_cntZero;
   logic             w_longGap;

   assign w_cntZero = (r_cnt == '0);
   assign w_longGap = !r_rsLat && ((r_byte == 8'h01) || (r_byte == 8'h02));

   // Next-state logic. Each timed state loads (length-1) on entry and leaves when the counter is 0;
   // PWR_WAIT alone counts upward because reset leaves the counter cleared.
   always_comb begin
      w_stateNext    = r_state;
      w_cntNext      = w_cntZero ? r_cnt : r_cnt - CNT_W'(1);
      w_initIdxNext  = r_initIdx;
      w_lowNibNext   = r_lowNib;
      w_byteNext     = r_byte;
      w_rsLatNext    = r_rsLat;
      w_rsNext       = r_rs;
      w_dataNext     = r_data;
      w_initDoneNext = r_initDone;

      case (r_state)
         PWR_WAIT: begin
            if (r_cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
               w_stateNext   = INIT_NIB;
               w_cntNext     = CNT_W'(SETUP_CYCLES - 1);
               w_initIdxNext = 2'd0;
               w_rsNext      = 1'b0;
               w_dataNext    = 4'h3;
            end else begin
               w_cntNext = r_cnt + CNT_W'(1);
            end
         end
         INIT_NIB, NIB_SETUP: begin
            if (w_cntZero) begin
               w_stateNext = NIB_EN;
               w_cntNext   = CNT_W'(EN_HIGH_CYCLES - 1);
            end
         end
         NIB_EN: begin
            if (w_cntZero) begin
               w_stateNext = NIB_HOLD;
               w_cntNext   = CNT_W'(HOLD_CYCLES - 1);
            end
         end
         NIB_HOLD: begin
            if (w_cntZero) begin
               if (!r_initDone) begin
                  w_stateNext = INIT_GAP;
                  w_cntNext   = CNT_W'(LONG_WAIT_CYCLES - 1);
               end else if (!r_lowNib) begin
                  w_stateNext  = NIB_SETUP;
                  w_cntNext    = CNT_W'(SETUP_CYCLES - 1);
                  w_lowNibNext = 1'b1;
                  w_dataNext   = r_byte[3:0];
               end else begin
                  w_stateNext = GAP;
                  w_cntNext   = w_longGap ? CNT_W'(LONG_WAIT_CYCLES - 1) : CNT_W'(CMD_WAIT_CYCLES - 1);
               end
            end
         end
         INIT_GAP: begin
            if (w_cntZero) begin
               if (r_initIdx == 2'd3) begin
                  w_stateNext    = IDLE;
                  w_initDoneNext = 1'b1;
               end else begin
                  w_stateNext   = INIT_NIB;
                  w_cntNext     = CNT_W'(SETUP_CYCLES - 1);
                  w_initIdxNext = r_initIdx + 2'd1;
                  w_dataNext    = (r_initIdx == 2'd2) ? 4'h2 : 4'h3;
               end
            end
         end
         IDLE: begin
            if (up.in_valid && r_ready) begin
               w_stateNext  = NIB_SETUP;
               w_cntNext    = CNT_W'(SETUP_CYCLES - 1);
               w_byteNext   = up.in_byte;
               w_rsLatNext  = up.in_rs;
               w_lowNibNext = 1'b0;
               w_rsNext     = up.in_rs;
               w_dataNext   = up.in_byte[7:4];
            end
         end
         GAP: begin
            if (w_cntZero) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = PWR_WAIT;
            w_cntNext   = '0;
         end
      endcase
   end

   // All bus-facing outputs are registered from the next state so en is glitch-free
   // and the async reset can drop it at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= PWR_WAIT;
         r_cnt      <= '0;
         r_initIdx  <= 2'd0;
         r_lowNib   <= 1'b0;
         r_byte     <= 8'h00;
         r_rsLat    <= 1'b0;
         r_rs       <= 1'b0;
         r_data     <= 4'h0;
         r_initDone <= 1'b0;
         r_en       <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b1;
      end else begin
         r_state    <= w_stateNext;
         r_cnt      <= w_cntNext;
         r_initIdx  <= w_initIdxNext;
         r_lowNib   <= w_lowNibNext;
         r_byte     <= w_byteNext;
         r_rsLat    <= w_rsLatNext;
         r_rs       <= w_rsNext;
         r_data     <= w_dataNext;
         r_initDone <= w_initDoneNext;
         r_en       <= (w_stateNext == NIB_EN);
         r_ready    <= (w_stateNext == IDLE);
         r_busy     <= (w_stateNext != IDLE);
      end
   end

   assign up.in_ready = r_ready;
   assign init_done   = r_initDone;
   assign busy        = r_busy;
   assign rs          = r_rs;
   assign en          = r_en;
   assign data        = r_data;

endmodule
